i2c_master_tx: RTL
==================

# i2c_master_tx

Write-only I2C master that drives SCL and SDA for the Triple-DES I2C link. It generates START, the 7-bit address with R/W=0, and a stream of data bytes pulled from a valid/ready source, then ends with STOP. Each byte's ACK is sampled from the bus. It is the initiator side of the bus whose edges the slave-side SCL edge detector observes, and it serves as the bus driver in system-level benches.

## Interface
- CLK_DIV, 250: system clocks per SCL quarter-period; at a 100 MHz clk this gives 100 kHz SCL; minimum 2.
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE, ignored otherwise.
- dev_addr  in  7  slave address, captured on accepted start.
- tx_data  in  8  data byte, MSB first on the bus.
- tx_valid  in  1  tx_data valid.
- tx_last  in  1  qualifies tx_data as the final byte.
- tx_ready  out  1  high only in HOLD; a byte transfers when tx_valid & tx_ready.
- sda_in  in  1  sampled bus SDA, pre-synchronized.
- scl_in  in  1  sampled bus SCL, pre-synchronized; used only with stretching enabled.
- scl_out  out  1  0 = drive low, 1 = release.
- sda_out  out  1  0 = drive low, 1 = release.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- nack_err  out  1  set on a NACK; held until the next accepted start.

## Operation
- States: IDLE, START, BIT, ACK, HOLD, STOP.
- Quarter tick: an internal counter counts 0..CLK_DIV-1 and pulses tick on the last count.
  - The counter runs in START, BIT, ACK and STOP.
  - It is held at 0 in IDLE and HOLD.
  - Every state transition below happens on a tick, except exits from IDLE and HOLD.
- IDLE: scl_out=1, sda_out=1. An accepted start latches the shift register as {dev_addr, 1'b0}, clears nack_err and goes to START.
- START, 2 quarters:
  - q0: SCL=1, SDA=1.
  - q1: SCL=1, SDA=0.
  - Then BIT with bit counter = 7.
- BIT, 4 quarters per bit:
  - q0: SCL=0, SDA=shift[7].
  - q1: SCL=0.
  - q2 and q3: SCL=1.
  - At the end of q3, shift left and decrement the bit counter. After bit 0, go to ACK.
- ACK, 4 quarters: same SCL pattern as BIT with sda_out=1. sda_in is sampled on the tick ending q2.
  - Sampled 1 (NACK): set nack_err and go to STOP.
  - Sampled 0, last byte already sent: go to STOP.
  - Sampled 0, otherwise: go to HOLD.
- HOLD: SCL=0, SDA=0, tx_ready=1, for at least 1 cycle.
  - On handshake: load tx_data, record tx_last, set bit counter = 7, go to BIT.
  - Waits indefinitely while tx_valid is low.
- STOP, 4 quarters:
  - q0: SCL=0, SDA=0.
  - q1: SCL=1, SDA=0.
  - q2: SCL=1, SDA=1.
  - q3: bus-free hold.
  - Then IDLE with a done pulse.
- Widths: quarter counter is $clog2(CLK_DIV) bits, bit counter 3 bits, shift register 8 bits.

## Timing
- Reset values: scl_out=1, sda_out=1, tx_ready=0, busy=0, done=0, nack_err=0, state=IDLE.
- Reset mid-transaction releases both lines immediately; no STOP is generated.
- busy rises the cycle after start is accepted.
- SDA changes only while SCL is low, except the START and STOP edges.
- Transaction with N data bytes and tx_valid always high:
  - done pulses (2 + 36(N+1) + 4)·CLK_DIV + N + 1 cycles after start is accepted.
  - For N=1 this is 78·CLK_DIV + 2.
- A NACK on the address byte skips all data bytes; done follows at (2 + 36 + 4)·CLK_DIV + 1.
- start in the same cycle as done is ignored; a new start is accepted from the cycle after done.

## Configuration
- I2C_CLK_STRETCH_EN defined:
  - In q3 of BIT and ACK and in q1 of STOP, the quarter counter does not advance while scl_out=1 and scl_in=0.
  - The slave can therefore extend SCL high-phase entry indefinitely.
- Undefined: scl_in is ignored and timing is exactly as above.

## Structure
- Shared package i2c_pkg holds:
  - the state enum i2c_mstate_t (IDLE, START, BIT, ACK, HOLD, STOP);
  - constants I2C_RELEASE=1'b1 and I2C_DRIVE_LOW=1'b0;
  - I2C_RW_WRITE=1'b0.
- Sub-module i2c_tick_gen, parameter CLK_DIV, holds the quarter counter.
  - Inputs: run, stall.
  - Output: tick.
  - Reused by the slave side for timeouts.

## Test plan
- Reset: rst=1 for 5 cycles, then check scl_out=1, sda_out=1, busy=0, tx_ready=0, done=0, nack_err=0.
- Single write: CLK_DIV=4, dev_addr=7'h2A, one byte 8'hC5 with tx_last=1, slave ACKs.
  - The bus decodes as START, 0x54, ACK, 0xC5, ACK, STOP.
  - done pulses at 314 cycles; nack_err=0.
- Address NACK: sda_in held 1, dev_addr=7'h10.
  - nack_err=1 after the address ACK slot, no tx_ready ever, STOP follows, done at 169 cycles.
- Back-pressure: two bytes, tx_valid withheld for 50 cycles in the first HOLD.
  - SCL stays low, tx_ready stays high, then transfer resumes.
  - Both bytes are on the bus in order.
- Reset mid-byte: assert rst during bit 4 of data.
  - Lines release in the same cycle, state=IDLE, no done pulse.
- Stretching (macro defined): hold scl_in=0 for 20 cycles at the first data-bit high phase.
  - done shifts later by exactly 20 cycles versus the unstretched run.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master FSM states and bus-level constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        HOLD,
        STOP
    } i2c_mstate_t;

    localparam logic I2C_RELEASE   = 1'b1;
    localparam logic I2C_DRIVE_LOW = 1'b0;
    localparam logic I2C_RW_WRITE  = 1'b0;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period tick generator: counts 0..CLK_DIV-1 while run is high, pulses tick on the last count.
// Cleared whenever run is low; stall freezes the count (used for SCL stretching and slave timeouts).
module i2c_tick_gen #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic stall,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (!stall) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = run && !stall && (cnt == LAST);

endmodule

// File: rtl/i2c_master_tx.sv
// Write-only I2C master: START, address+W, valid/ready-fed data bytes with ACK check, STOP.
// Optional SCL clock stretching by the slave when I2C_CLK_STRETCH_EN is defined.
module i2c_master_tx
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       scl_out,
    output logic       sda_out,
    output logic       busy,
    output logic       done,
    output logic       nack_err
);

    i2c_mstate_t state;
    logic [1:0]  q;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        last_byte;
    logic        run;
    logic        stall;
    logic        tick;

    assign run = (state == START) || (state == BIT) || (state == ACK) || (state == STOP);

`ifdef I2C_CLK_STRETCH_EN
    // Freeze only where we have just released SCL and the slave still holds it low.
    assign stall = scl_out && !scl_in &&
                   ((((state == BIT) || (state == ACK)) && (q == 2'd3)) ||
                    ((state == STOP) && (q == 2'd1)));
`else
    assign stall = 1'b0 & scl_in;
`endif

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .stall (stall),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            q         <= 2'd0;
            bit_cnt   <= 3'd0;
            shift     <= 8'd0;
            last_byte <= 1'b0;
            scl_out   <= I2C_RELEASE;
            sda_out   <= I2C_RELEASE;
            tx_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            nack_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        shift     <= {dev_addr, I2C_RW_WRITE};
                        last_byte <= 1'b0;
                        nack_err  <= 1'b0;
                        busy      <= 1'b1;
                        q         <= 2'd0;
                        state     <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (q == 2'd0) begin
                            q       <= 2'd1;
                            sda_out <= I2C_DRIVE_LOW;
                        end else begin
                            q       <= 2'd0;
                            bit_cnt <= 3'd7;
                            scl_out <= I2C_DRIVE_LOW;
                            sda_out <= shift[7];
                            state   <= BIT;
                        end
                    end
                end
                BIT: begin
                    if (tick) begin
                        q <= q + 2'd1;
                        if (q == 2'd1) scl_out <= I2C_RELEASE;
                        if (q == 2'd3) begin
                            shift   <= shift << 1;
                            scl_out <= I2C_DRIVE_LOW;
                            if (bit_cnt == 3'd0) begin
                                sda_out <= I2C_RELEASE;
                                state   <= ACK;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                                sda_out <= shift[6];
                            end
                        end
                    end
                end
                ACK: begin
                    if (tick) begin
                        q <= q + 2'd1;
                        if (q == 2'd1) scl_out <= I2C_RELEASE;
                        if ((q == 2'd2) && (sda_in == I2C_RELEASE)) nack_err <= 1'b1;
                        if (q == 2'd3) begin
                            scl_out <= I2C_DRIVE_LOW;
                            sda_out <= I2C_DRIVE_LOW;
                            if (nack_err || last_byte) begin
                                state <= STOP;
                            end else begin
                                tx_ready <= 1'b1;
                                state    <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tx_valid && tx_ready) begin
                        shift     <= tx_data;
                        last_byte <= tx_last;
                        bit_cnt   <= 3'd7;
                        tx_ready  <= 1'b0;
                        sda_out   <= tx_data[7];
                        q         <= 2'd0;
                        state     <= BIT;
                    end
                end
                STOP: begin
                    if (tick) begin
                        q <= q + 2'd1;
                        if (q == 2'd0) scl_out <= I2C_RELEASE;
                        if (q == 2'd1) sda_out <= I2C_RELEASE;
                        if (q == 2'd3) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
